// File: rtl/serial_rx_buffer.sv
// Serial receiver front end: captures each held frame exactly once, pulses
// flush to release the receiver, and queues frames in a first-word fall-through FIFO.
module serial_rx_buffer #(
  parameter int PKT_W = 42,
  parameter int PAD_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     receiver_valid,
  input  logic [PKT_W-1:0]         receiver_packet,
  input  logic [PAD_W-1:0]         receiver_padding,
  output logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PKT_W-1:0]         out_packet,
  output logic [PAD_W-1:0]         out_padding,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = PKT_W + PAD_W;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    WAIT_VALID = 2'd0,
    FLUSH      = 2'd1,
    WAIT_DROP  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] head;
  logic               push, pop;

  // Full check uses the registered count, so a same-cycle pop never frees a slot.
  assign push = (state == WAIT_VALID) && receiver_valid && (count < FULL_CNT);
  assign pop  = out_valid && out_ready;

  // NOTE: every signal written in always_comb gets a default first; this is what
  // keeps the block free of inferred latches when a branch forgets an assignment.
  always_comb begin
    state_nxt = state;
    unique case (state)
      WAIT_VALID: if (push) state_nxt = FLUSH;
      FLUSH:      state_nxt = WAIT_DROP;
      WAIT_DROP:  if (!receiver_valid) state_nxt = WAIT_VALID;
      default:    state_nxt = WAIT_VALID;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= WAIT_VALID;
    else      state <= state_nxt;
  end

  assign flush = (state == FLUSH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is cleared on reset because the head entry is visible on the
  // outputs combinationally; without the clear, out_packet would show stale data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= {receiver_packet, receiver_padding};
    end
  end

  assign head        = mem[rd_ptr];
  assign out_valid   = (count != '0);
  assign out_packet  = head[ENTRY_W-1:PAD_W];
  assign out_padding = head[PAD_W-1:0];

endmodule

// File: tb/tb_serial_rx_buffer.sv
// Directed bench for serial_rx_buffer: a frame scoreboard queue is filled when a
// frame is offered and drained as the consumer pops the FIFO head.
module tb_serial_rx_buffer;

  localparam int PKT_W = 42;
  localparam int PAD_W = 4;
  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               receiver_valid = 1'b0;
  logic [PKT_W-1:0]   receiver_packet = '0;
  logic [PAD_W-1:0]   receiver_padding = '0;
  logic               flush;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [PKT_W-1:0]   out_packet;
  logic [PAD_W-1:0]   out_padding;
  logic [$clog2(DEPTH):0] count;

  serial_rx_buffer #(.PKT_W(PKT_W), .PAD_W(PAD_W), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .receiver_valid   (receiver_valid),
    .receiver_packet  (receiver_packet),
    .receiver_padding (receiver_padding),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_packet       (out_packet),
    .out_padding      (out_padding),
    .count            (count)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int flush_cnt   = 0;
  int pop_cnt     = 0;
  bit toggle_en   = 1'b0;
  logic [PKT_W+PAD_W-1:0] sb_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle monitor: a pop happens at the coming edge, so compare the head now.
  always @(negedge clk) begin
    if (rst && flush) flush_cnt++;
    if (rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("pop_unexpected", 64'(sb_q.size()), 64'd1);
      end else begin
        check("pop_frame", 64'({out_packet, out_padding}), 64'(sb_q.pop_front()));
        pop_cnt++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
    if (toggle_en) out_ready = ~out_ready;
  endtask

  // Present a frame, wait (bounded) for its flush, then release the level.
  task automatic offer(input logic [PKT_W-1:0] pkt, input logic [PAD_W-1:0] pad);
    bit got = 1'b0;
    receiver_packet  = pkt;
    receiver_padding = pad;
    receiver_valid   = 1'b1;
    sb_q.push_back({pkt, pad});
    for (int i = 0; i < 40; i++) begin
      tick();
      if (flush) begin
        got = 1'b1;
        break;
      end
    end
    check("offer_flush_seen", 64'(got), 64'd1);
    receiver_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic drain;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && out_valid; i++) tick();
    check("drain_count", 64'(count), 64'd0);
    check("drain_queue_empty", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    int f0;
    int p0;

    // Reset state
    #3;
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_flush", 64'(flush), 64'd0);
    check("rst_out_data", 64'({out_packet, out_padding}), 64'd0);
    tick();
    rst = 1'b1;
    tick();

    // Single frame with consumer ready
    out_ready        = 1'b1;
    receiver_packet  = 42'h24c65316459;
    receiver_padding = 4'b1011;
    receiver_valid   = 1'b1;
    sb_q.push_back({42'h24c65316459, 4'b1011});
    tick();
    check("single_flush", 64'(flush), 64'd1);
    check("single_out_valid", 64'(out_valid), 64'd1);
    check("single_out_packet", 64'(out_packet), 64'h24c65316459);
    check("single_out_padding", 64'(out_padding), 64'hb);
    check("single_count", 64'(count), 64'd1);
    receiver_valid = 1'b0;
    tick();
    check("single_flush_one_cycle", 64'(flush), 64'd0);
    check("single_count_back", 64'(count), 64'd0);
    check("single_out_valid_low", 64'(out_valid), 64'd0);
    tick();

    // Fill with backpressure, then release the consumer
    out_ready = 1'b0;
    f0 = flush_cnt;
    for (int i = 0; i < DEPTH; i++) offer(42'(64'h100 + i), 4'(i + 3));
    check("fill_count_full", 64'(count), 64'd4);
    check("fill_flush_pulses", 64'(flush_cnt - f0), 64'd4);
    receiver_packet  = 42'h3ff_0000_0005;
    receiver_padding = 4'h5;
    receiver_valid   = 1'b1;
    sb_q.push_back({42'h3ff_0000_0005, 4'h5});
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fill_held_no_flush", 64'(flush), 64'd0);
      check("fill_held_count", 64'(count), 64'd4);
    end
    out_ready = 1'b1;
    tick();
    check("fill_pop_no_push_flush", 64'(flush), 64'd0);
    check("fill_pop_no_push_count", 64'(count), 64'd3);
    tick();
    check("fill_fifth_flush", 64'(flush), 64'd1);
    check("fill_fifth_count", 64'(count), 64'd3);
    receiver_valid = 1'b0;
    drain();
    check("fill_total_flushes", 64'(flush_cnt - f0), 64'd5);
    tick();

    // Wrap: ten frames with out_ready toggling every cycle
    p0 = pop_cnt;
    out_ready = 1'b0;
    toggle_en = 1'b1;
    for (int i = 1; i <= 10; i++) offer(42'(i), 4'(i));
    toggle_en = 1'b0;
    drain();
    check("wrap_pops", 64'(pop_cnt - p0), 64'd10);
    tick();

    // Stale level: receiver holds valid for 3 cycles after flush
    out_ready = 1'b0;
    f0 = flush_cnt;
    receiver_packet  = 42'h155_5555_5555;
    receiver_padding = 4'h9;
    receiver_valid   = 1'b1;
    sb_q.push_back({42'h155_5555_5555, 4'h9});
    tick();
    check("stale_flush", 64'(flush), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stale_no_flush", 64'(flush), 64'd0);
      check("stale_count", 64'(count), 64'd1);
    end
    receiver_valid = 1'b0;
    tick();
    tick();
    check("stale_single_capture", 64'(flush_cnt - f0), 64'd1);
    check("stale_count_after", 64'(count), 64'd1);
    drain();
    tick();

    // Simultaneous push and pop at count=2
    out_ready = 1'b0;
    offer(42'h0aa, 4'h1);
    offer(42'h0bb, 4'h2);
    check("simul_pre_count", 64'(count), 64'd2);
    receiver_packet  = 42'h0cc;
    receiver_padding = 4'h3;
    receiver_valid   = 1'b1;
    sb_q.push_back({42'h0cc, 4'h3});
    out_ready = 1'b1;
    tick();
    check("simul_count", 64'(count), 64'd2);
    check("simul_flush", 64'(flush), 64'd1);
    check("simul_head_advanced", 64'(out_packet), 64'h0bb);
    out_ready      = 1'b0;
    receiver_valid = 1'b0;
    tick();
    tick();
    drain();
    tick();

    // Asynchronous reset between edges with count=3 and a flush pending
    out_ready = 1'b0;
    offer(42'h011, 4'h4);
    offer(42'h022, 4'h5);
    receiver_packet  = 42'h033;
    receiver_padding = 4'h6;
    receiver_valid   = 1'b1;
    tick();
    check("arst_pre_count", 64'(count), 64'd3);
    check("arst_pre_flush", 64'(flush), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_flush", 64'(flush), 64'd0);
    check("arst_out_data", 64'({out_packet, out_padding}), 64'd0);
    sb_q.delete();
    sb_q.push_back({42'h033, 4'h6});
    tick();
    check("arst_hold_count", 64'(count), 64'd0);
    rst = 1'b1;
    tick();
    check("arst_recapture_flush", 64'(flush), 64'd1);
    check("arst_recapture_count", 64'(count), 64'd1);
    check("arst_recapture_packet", 64'(out_packet), 64'h033);
    receiver_valid = 1'b0;
    tick();
    tick();
    drain();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
